// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC run controller for the 4-bit accumulator CPU.
// Define CPU_SEQ_BREAKPOINT_EN to build the PC breakpoint ports and logic.
module cpu_sequencer #(
    parameter int unsigned IW           = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned RUN_ON_RESET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             stop_req,
    input  logic [IW-1:0]    rom_data,
    input  logic [3:0]       dec_ld,
    input  logic             dec_hlt,
`ifdef CPU_SEQ_BREAKPOINT_EN
    input  logic [3:0]       pc_val,
    input  logic [3:0]       bp_addr,
    input  logic             bp_arm,
    output logic             bp_hit,
`endif
    output logic [IW-1:0]    ir,
    output logic [3:0]       ld,
    output logic             pc_inc,
    output logic             flag_we,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam state_t RST_STATE   = (RUN_ON_RESET != 0) ? S_FETCH : S_IDLE;
    localparam logic   RST_RUNNING = (RUN_ON_RESET != 0);

    state_t           state;
    state_t           state_d;
    logic [IW-1:0]    ir_d;
    logic             running_d;
    logic             halted_d;
    logic [CNT_W-1:0] retired_d;
    logic             stop_q;
    logic             stop_d;
    logic             bp_take;

`ifdef CPU_SEQ_BREAKPOINT_EN
    logic bp_skip;

    // The first fetch after a breakpoint stop is exempt so the stopped instruction can run.
    assign bp_take = running & bp_arm & (pc_val == bp_addr) & ~bp_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_hit  <= 1'b0;
            bp_skip <= 1'b0;
        end else begin
            bp_hit  <= (state == S_FETCH) & bp_take;
            if (state == S_FETCH) begin
                bp_skip <= bp_take;
            end
        end
    end
`else
    assign bp_take = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir      <= '0;
            running <= RST_RUNNING;
            halted  <= 1'b0;
            retired <= '0;
            stop_q  <= 1'b0;
        end else begin
            ir      <= ir_d;
            running <= running_d;
            halted  <= halted_d;
            retired <= retired_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state and commit strobes; strobes are only ever live in EXEC.
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        running_d = running;
        halted_d  = halted;
        retired_d = retired;
        stop_d    = stop_q;
        ld        = 4'b0000;
        pc_inc    = 1'b0;
        flag_we   = 1'b0;

        case (state)
            S_IDLE: begin
                if (step_req) begin
                    state_d   = S_FETCH;
                    running_d = 1'b0;
                end else if (run_req && !stop_req) begin
                    state_d   = S_FETCH;
                    running_d = 1'b1;
                end
            end
            S_FETCH: begin
                stop_d = stop_q | stop_req;
                if (bp_take) begin
                    state_d   = S_IDLE;
                    running_d = 1'b0;
                    stop_d    = 1'b0;
                end else begin
                    ir_d    = rom_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                stop_d = stop_q | stop_req;
                if (dec_hlt) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else begin
                    ld      = dec_ld;
                    pc_inc  = ~dec_ld[3];
                    flag_we = 1'b1;
                    if (retired != {CNT_W{1'b1}}) begin
                        retired_d = retired + CNT_W'(1);
                    end
                    if (running && !(stop_q || stop_req)) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d   = S_IDLE;
                        running_d = 1'b0;
                        stop_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase

        // A reset cycle must never commit anything, even mid-EXEC.
        if (rst) begin
            ld      = 4'b0000;
            pc_inc  = 1'b0;
            flag_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed table, corner sequences and random run against a reference model,
// with a bench-side PC, ROM and decoder closing the loop around the sequencer.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_req = 1'b0;
    logic       step_req = 1'b0;
    logic       stop_req = 1'b0;
    logic [7:0] rom_data;
    logic [3:0] dec_ld;
    logic       dec_hlt;
    logic [7:0] ir;
    logic [3:0] ld;
    logic       pc_inc;
    logic       flag_we;
    logic       running;
    logic       halted;
    logic [7:0] retired;
    logic [3:0] pc;
    logic [7:0] rom [16];
`ifdef CPU_SEQ_BREAKPOINT_EN
    logic [3:0] bp_addr = 4'd0;
    logic       bp_arm = 1'b0;
    logic       bp_hit;
`endif

    int nchk = 0;
    int nfail = 0;

    // Reference model state: phase 0 idle, 1 fetch, 2 exec, 3 halted.
    int         m_ph = 0;
    bit         m_run = 0;
    bit         m_stop = 0;
    bit         m_valid = 0;
    logic [7:0] m_ir = 8'h00;
    logic [7:0] m_ret = 8'h00;
`ifdef CPU_SEQ_BREAKPOINT_EN
    bit         m_skip = 0;
    bit         m_bp = 0;
`endif

    typedef struct {
        bit          r;
        bit          ru;
        bit          st;
        bit          sp;
        logic [15:0] exp;
    } vec_t;
    vec_t tab[$];

    always #5 clk = ~clk;

    // Opcodes: 1 MOV A, 2 ADD A, 3 MOV B, 4 OUT, 5 JMP, F HLT, others NOP.
    function automatic logic [3:0] dec_ld_f(input logic [7:0] i);
        case (i[7:4])
            4'h1, 4'h2: return 4'b0001;
            4'h3:       return 4'b0010;
            4'h4:       return 4'b0100;
            4'h5:       return 4'b1000;
            default:    return 4'b0000;
        endcase
    endfunction

    assign rom_data = rom[pc];
    assign dec_ld   = dec_ld_f(ir);
    assign dec_hlt  = (ir[7:4] == 4'hF);

    always @(posedge clk) begin
        if (rst)         pc <= 4'd0;
        else if (ld[3])  pc <= ir[3:0];
        else if (pc_inc) pc <= pc + 4'd1;
    end

    cpu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .run_req  (run_req),
        .step_req (step_req),
        .stop_req (stop_req),
        .rom_data (rom_data),
        .dec_ld   (dec_ld),
        .dec_hlt  (dec_hlt),
`ifdef CPU_SEQ_BREAKPOINT_EN
        .pc_val   (pc),
        .bp_addr  (bp_addr),
        .bp_arm   (bp_arm),
        .bp_hit   (bp_hit),
`endif
        .ir       (ir),
        .ld       (ld),
        .pc_inc   (pc_inc),
        .flag_we  (flag_we),
        .running  (running),
        .halted   (halted),
        .retired  (retired)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare, advance the model, wait for next fall.
    task automatic tick(input bit r, input bit ru, input bit st, input bit sp,
                        input bit use_tab, input logic [15:0] texp);
        logic [3:0] dl;
        logic [3:0] eld;
        bit         dh;
        bit         epi;
        bit         efw;
        bit         bp_go;
        bit         bp_nx;
        rst = r; run_req = ru; step_req = st; stop_req = sp;
        #1;
        if (use_tab)
            chk("table", {16'h0, ld, pc_inc, flag_we, running, halted, retired}, {16'h0, texp});
        dl = dec_ld_f(m_ir);
        dh = (m_ir[7:4] == 4'hF);
        if (m_valid) begin
            eld = 4'b0000; epi = 0; efw = 0;
            if (m_ph == 2 && !dh && !r) begin
                eld = dl; epi = !dl[3]; efw = 1;
            end
            chk("model", {8'h0, ir, ld, pc_inc, flag_we, running, halted, retired},
                {8'h0, m_ir, eld, epi, efw, m_run, (m_ph == 3), m_ret});
`ifdef CPU_SEQ_BREAKPOINT_EN
            chk("bp_hit", {31'h0, bp_hit}, {31'h0, m_bp});
`endif
        end
        bp_go = 0;
        bp_nx = 0;
`ifdef CPU_SEQ_BREAKPOINT_EN
        bp_go = m_run && bp_arm && (pc == bp_addr) && !m_skip;
`endif
        if (r) begin
            m_ph = 0; m_run = 0; m_stop = 0; m_ir = 8'h00; m_ret = 8'h00; m_valid = 1;
`ifdef CPU_SEQ_BREAKPOINT_EN
            m_skip = 0;
`endif
        end else begin
            case (m_ph)
                0: begin
                    if (st) begin
                        m_ph = 1; m_run = 0;
                    end else if (ru && !sp) begin
                        m_ph = 1; m_run = 1;
                    end
                end
                1: begin
                    if (sp) m_stop = 1;
                    if (bp_go) begin
                        m_ph = 0; m_run = 0; m_stop = 0; bp_nx = 1;
                    end else begin
                        m_ir = rom_data; m_ph = 2;
                    end
`ifdef CPU_SEQ_BREAKPOINT_EN
                    m_skip = bp_go;
`endif
                end
                2: begin
                    if (sp) m_stop = 1;
                    if (dh) begin
                        m_ph = 3;
                    end else begin
                        if (m_ret != 8'hFF) m_ret = m_ret + 8'd1;
                        if (m_run && !m_stop) begin
                            m_ph = 1;
                        end else begin
                            m_ph = 0; m_run = 0; m_stop = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
`ifdef CPU_SEQ_BREAKPOINT_EN
        m_bp = bp_nx;
`endif
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit ru, input bit st, input bit sp);
        tick(r, ru, st, sp, 1'b0, 16'h0);
    endtask

    task automatic add(input bit r, input bit ru, input bit st, input bit sp,
                       input logic [3:0] l, input bit pi, input bit fw, input bit rn,
                       input bit hl, input logic [7:0] ret);
        vec_t v;
        v.r = r; v.ru = ru; v.st = st; v.sp = sp;
        v.exp = {l, pi, fw, rn, hl, ret};
        tab.push_back(v);
    endtask

    task automatic load_p1();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h15;
        rom[1] = 8'h21;
        rom[2] = 8'h21;
        rom[3] = 8'h21;
        rom[4] = 8'h50;
    endtask

    function automatic logic [7:0] rand_insn();
        logic [3:0] ops [8];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h2, 4'h1};
        if ($urandom_range(0, 23) == 0) return 8'hF0;
        return {ops[$urandom_range(0, 7)], 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        int n;
        load_p1();
        @(negedge clk);

        // Reset and quiet idle.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reset_state", {8'h0, ir, ld, pc_inc, flag_we, running, halted, retired}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            chk("idle_no_ld", {26'h0, ld, pc_inc, flag_we}, 32'h0);
        end

        // Step, run, JMP, stop in FETCH, run+stop ignored, step beats run, run in FETCH ignored.
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd0);
        add(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd1);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd1);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 8'd1);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0, 8'd1);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 8'd2);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0, 8'd2);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 8'd3);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0, 8'd3);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 8'd4);
        add(0, 0, 0, 0, 4'b1000, 0, 1, 1, 0, 8'd4);
        add(0, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 8'd5);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0, 8'd5);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd6);
        add(0, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 8'd6);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd7);
        foreach (tab[i]) tick(tab[i].r, tab[i].ru, tab[i].st, tab[i].sp, 1'b1, tab[i].exp);
        chk("pc_after_table", {28'h0, pc}, 32'd2);

        // HLT at PC 3: sticky, ignores requests, cleared only by reset.
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h21; rom[1] = 8'h21; rom[2] = 8'h21; rom[3] = 8'hF0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n = 0;
        while (!halted && n < 30) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("hlt_reached", {31'h0, halted}, 32'd1);
        chk("hlt_retired", {24'h0, retired}, 32'd3);
        chk("hlt_pc", {28'h0, pc}, 32'd3);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("hlt_quiet", {25'h0, ld, pc_inc, flag_we, halted}, 32'd1);
        end
        cyc(1, 0, 0, 0);
        chk("hlt_reset", {22'h0, running, halted, retired}, 32'h0);
        cyc(0, 0, 0, 0);

        // Reset asserted in the EXEC cycle of an ADD.
        load_p1();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n = 0;
        while (!(m_ph == 2 && m_ir[7:4] == 4'h2) && n < 20) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("exec_add_found", {31'h0, flag_we}, 32'd1);
        rst = 1;
        #1;
        chk("rst_exec_strobes", {26'h0, ld, pc_inc, flag_we}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("rst_exec_after", {22'h0, running, halted, retired}, 32'h0);
        cyc(0, 0, 0, 0);

        // Saturation of the retired counter (PC also wraps 15 -> 0 on the way).
        for (int i = 0; i < 16; i++) rom[i] = 8'h21;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 540; i++) cyc(0, 0, 0, 0);
        chk("retired_sat", {23'h0, running, retired}, {23'h0, 1'b1, 8'hFF});
        cyc(1, 0, 0, 0);

`ifdef CPU_SEQ_BREAKPOINT_EN
        // Breakpoint at PC 2, then resume executes PC 2 exactly once before moving on.
        load_p1();
        bp_addr = 4'd2;
        bp_arm  = 1;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n = 0;
        while (!bp_hit && n < 20) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("bp_fired", {31'h0, bp_hit}, 32'd1);
        chk("bp_state", {19'h0, running, pc, retired}, {19'h0, 1'b0, 4'd2, 8'd2});
        cyc(0, 1, 0, 0);
        n = 0;
        while (retired != 8'd3 && n < 10) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("bp_resume", {19'h0, running, pc, retired}, {19'h0, 1'b1, 4'd3, 8'd3});
        cyc(0, 0, 0, 1);
        n = 0;
        while (running && n < 10) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("bp_stop", {31'h0, running}, 32'd0);
        bp_arm = 0;
`endif

        // Random programs and front-panel pulses against the model.
        for (int i = 0; i < 16; i++) rom[i] = rand_insn();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 299) rom[$urandom_range(0, 15)] = rand_insn();
            cyc(($urandom_range(0, 149) == 0) || (halted && $urandom_range(0, 9) == 0),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
